// File: rtl/pulse_peak_detector_pkg.sv
// Shared types for the pulse peak detector: FSM states, event record and tdata packing.
package pulse_det_pkg;

   localparam int ADC_W_DEF   = 14;
   localparam int TS_W_DEF    = 18;
   localparam int TDATA_W_DEF = ADC_W_DEF + TS_W_DEF;

   typedef enum logic [1:0] {IDLE, PULSE, OVERLONG} pdet_state_t;

   typedef struct packed {
      logic signed [ADC_W_DEF-1:0] peak;
      logic [TS_W_DEF-1:0]         ts;
   } pdet_evt_t;

   function automatic logic [TDATA_W_DEF-1:0] pdet_pack(input pdet_evt_t e);
      return {e.peak, e.ts};
   endfunction

endpackage

// File: rtl/pulse_peak_detector_if.sv
// AXI4-Stream event channel from the detector toward the DMA/histogram path.
interface pulse_peak_detector_if #(parameter int W = 32);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/pulse_peak_detector_fifo.sv
// Show-ahead event FIFO; exposes the head and the entry behind it so the
// output register can advance on the same edge that pops.
module pdet_event_fifo
   import pulse_det_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  pdet_evt_t wdata,
   input  logic      pop,
   output logic      accept,
   output logic      empty,
   output logic      multi,
   output pdet_evt_t head,
   output pdet_evt_t head_nxt
);

   localparam int AW = $clog2(DEPTH);

   pdet_evt_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
   logic [AW:0]     cnt;
   logic            full, do_pop;

   assign full     = (cnt == (AW+1)'(DEPTH));
   assign empty    = (cnt == '0);
   assign multi    = (cnt > (AW+1)'(1));
   assign do_pop   = pop && !empty;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign accept   = push && (!full || do_pop);
   assign rd_nxt   = rd_ptr + 1'b1;
   assign head     = mem[rd_ptr];
   assign head_nxt = mem[rd_nxt];

   always_ff @(posedge clk)
      if (accept) mem[wr_ptr] <= wdata;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_nxt;
         case ({accept, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/pulse_peak_detector.sv
// Hysteresis pulse detector: finds the peak and its timestamp of each pulse on the
// filtered ADC stream and streams the events out through a buffered AXIS master.
module pulse_peak_detector
   import pulse_det_pkg::*;
#(
   parameter int ADC_WIDTH        = ADC_W_DEF,
   parameter int AXIS_TDATA_WIDTH = TDATA_W_DEF,
   parameter int TS_WIDTH         = TS_W_DEF,
   parameter int MAX_LEN          = 256,
   parameter int FIFO_DEPTH       = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic signed [ADC_WIDTH-1:0] adc_filt_a,
   input  logic                        cfg_en,
   input  logic signed [ADC_WIDTH-1:0] cfg_thr_hi,
   input  logic signed [ADC_WIDTH-1:0] cfg_thr_lo,
   pulse_peak_detector_if.master       m_axis,
   output logic [31:0]                 evt_count,
   output logic [15:0]                 drop_count
);

   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   pdet_state_t                 state, state_n;
   logic signed [ADC_WIDTH-1:0] s, peak, peak_n;
   logic [TS_WIDTH-1:0]         ts, pk_ts, pk_ts_n;
   logic [LEN_W-1:0]            len, len_n;
   logic                        push, ovl;

   logic                        accept, empty, multi, pop;
   pdet_evt_t                   evt, head, head_nxt;
   logic [AXIS_TDATA_WIDTH-1:0] tdata_q;
   logic                        tvalid_q;

   always_ff @(posedge clk)
      s <= adc_filt_a;

   always_ff @(posedge clk) begin
      if (!reset) ts <= '0;
      else        ts <= ts + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         peak  <= '0;
         pk_ts <= '0;
         len   <= '0;
      end else begin
         state <= state_n;
         peak  <= peak_n;
         pk_ts <= pk_ts_n;
         len   <= len_n;
      end
   end

   always_comb begin
      state_n = state;
      peak_n  = peak;
      pk_ts_n = pk_ts;
      len_n   = len;
      push    = 1'b0;
      ovl     = 1'b0;
      if (!cfg_en) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE:
               if (s >= cfg_thr_hi) begin
                  state_n = PULSE;
                  peak_n  = s;
                  pk_ts_n = ts;
                  len_n   = LEN_W'(1);
               end
            PULSE:
               if (s < cfg_thr_lo) begin
                  state_n = IDLE;
                  push    = 1'b1;
               end else if (len == LEN_MAX) begin
                  state_n = OVERLONG;
                  ovl     = 1'b1;
               end else begin
                  len_n = len + 1'b1;
                  // Strict compare: a plateau keeps the earliest timestamp.
                  if (s > peak) begin
                     peak_n  = s;
                     pk_ts_n = ts;
                  end
               end
            OVERLONG:
               if (s < cfg_thr_lo) state_n = IDLE;
            default:
               state_n = IDLE;
         endcase
      end
   end

   assign evt.peak = peak;
   assign evt.ts   = pk_ts;

   pdet_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .wdata    (evt),
      .pop      (pop),
      .accept   (accept),
      .empty    (empty),
      .multi    (multi),
      .head     (head),
      .head_nxt (head_nxt)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         evt_count  <= '0;
         drop_count <= '0;
      end else begin
         if (accept) evt_count <= evt_count + 1'b1;
         if ((ovl || (push && !accept)) && drop_count != 16'hFFFF)
            drop_count <= drop_count + 1'b1;
      end
   end

   // The output register mirrors the FIFO head, which stays stored until accepted.
   assign pop = tvalid_q && m_axis.tready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
      end else if (pop) begin
         tvalid_q <= multi;
         if (multi) tdata_q <= pdet_pack(head_nxt);
      end else if (!tvalid_q && !empty) begin
         tvalid_q <= 1'b1;
         tdata_q  <= pdet_pack(head);
      end
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed and randomized bench for pulse_peak_detector against a queue-based event model.
module tb_pulse_peak_detector;

   localparam int MAXL  = 8;
   localparam int DEPTH = 16;
   localparam logic [31:0] T1_EXP = {14'd1800, 18'd12};

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               en = 1'b0;
   logic signed [13:0] adc = '0;
   logic signed [13:0] hi = 14'sd1000;
   logic signed [13:0] lo = 14'sd500;
   logic [31:0]        evt_count;
   logic [15:0]        drop_count;

   pulse_peak_detector_if #(.W(32)) axis ();

   pulse_peak_detector #(.MAX_LEN(MAXL), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .adc_filt_a (adc),
      .cfg_en     (en),
      .cfg_thr_hi (hi),
      .cfg_thr_lo (lo),
      .m_axis     (axis),
      .evt_count  (evt_count),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   // Reference model: collects the samples of the current pulse and picks the
   // first maximum when the pulse closes; the FIFO is a queue of expected beats.
   int          ts_m = 0, prev_s = 0, prev_ts = 0;
   bit          active = 0, ovl_m = 0, m_vld = 0, chk_on = 0;
   int          pq_v[$], pq_t[$];
   logic [31:0] exp_q[$];
   logic [31:0] evt_m = '0;
   logic [15:0] drop_m = '0;
   logic [31:0] last_beat = '0;
   int          beats = 0;

   always @(posedge clk) begin : model
      bit          pop, emit, acc;
      int          cnt_b, best, tv, tt;
      logic [31:0] ev;
      logic [13:0] p14;
      logic [17:0] t18;
      pop   = m_vld && axis.tready;
      cnt_b = exp_q.size();
      emit  = 0;
      ev    = '0;
      if (!rst_n) begin
         active = 0; ovl_m = 0; m_vld = 0;
         pq_v.delete(); pq_t.delete(); exp_q.delete();
         evt_m = '0; drop_m = '0;
      end else begin
         if (!en) begin
            active = 0; ovl_m = 0;
            pq_v.delete(); pq_t.delete();
         end else if (ovl_m) begin
            if (prev_s < int'(lo)) ovl_m = 0;
         end else if (!active) begin
            if (prev_s >= int'(hi)) begin
               active = 1;
               pq_v.push_back(prev_s);
               pq_t.push_back(prev_ts);
            end
         end else if (prev_s < int'(lo)) begin
            best = 0;
            foreach (pq_v[i]) if (pq_v[i] > pq_v[best]) best = i;
            tv = pq_v[best];
            tt = pq_t[best];
            p14 = tv[13:0];
            t18 = tt[17:0];
            ev = {p14, t18};
            emit = 1;
            active = 0;
            pq_v.delete(); pq_t.delete();
         end else if (pq_v.size() == MAXL) begin
            active = 0; ovl_m = 1;
            pq_v.delete(); pq_t.delete();
            if (drop_m != 16'hFFFF) drop_m++;
         end else begin
            pq_v.push_back(prev_s);
            pq_t.push_back(prev_ts);
         end
         acc = emit && (cnt_b < DEPTH || pop);
         if (acc) evt_m++;
         else if (emit && drop_m != 16'hFFFF) drop_m++;
         // An event becomes visible one edge after it is stored.
         if (pop) m_vld = (cnt_b > 1);
         else if (!m_vld) m_vld = (cnt_b > 0);
         if (pop) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(ev);
      end
      ts_m = rst_n ? ((ts_m + 1) & 32'h3FFFF) : 0;
      prev_s  = int'(adc);
      prev_ts = ts_m;
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("tvalid", axis.tvalid, m_vld);
         if (m_vld && exp_q.size() > 0) chk("tdata", axis.tdata, exp_q[0]);
         chk("evt_count", evt_count, evt_m);
         chk("drop_count", drop_count, drop_m);
         if (axis.tvalid && axis.tready) begin
            last_beat = axis.tdata;
            beats++;
         end
      end
   end

   task automatic cyc(input int v);
      adc = 14'(v);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int lim);
      int n = 0;
      axis.tready = 1'b1;
      while ((exp_q.size() != 0 || m_vld) && n < lim) begin
         cyc(0);
         n++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin
      int          b0, v, burst;
      logic [17:0] t18;
      logic [31:0] exp2;
      axis.tready = 1'b1;
      en = 1'b1;

      rst_n = 1'b0;
      cyc(0);
      chk_on = 1;
      chk("rst_tvalid", axis.tvalid, 0);
      chk("rst_tdata", axis.tdata, 0);
      chk("rst_evt", evt_count, 0);
      chk("rst_drop", drop_count, 0);

      // 1: basic pulse, sample 0 lands on ts 10
      rst_n = 1'b1;
      repeat (9) cyc(0);
      cyc(0); cyc(1200); cyc(1800); cyc(1500); cyc(400);
      cyc(0);
      chk("t1_lat_k1", axis.tvalid, 0);
      cyc(0);
      chk("t1_lat_k2", axis.tvalid, 1);
      cyc(0); cyc(0);
      chk("t1_beat", last_beat, T1_EXP);
      chk("t1_evt", evt_count, 1);

      // 2: plateau keeps the first timestamp
      cyc(1200); cyc(1300);
      t18 = prev_ts[17:0];
      exp2 = {14'd1300, t18};
      cyc(1300); cyc(1100); cyc(0);
      repeat (4) cyc(0);
      chk("t2_beat", last_beat, exp2);

      // 3: overlong pulse
      b0 = beats;
      repeat (20) cyc(2000);
      repeat (4) cyc(0);
      chk("t3_drop", drop_count, 1);
      chk("t3_evt", evt_count, 2);
      chk("t3_beats", beats, b0);

      // 4: stalled sink, FIFO overflow
      b0 = beats;
      axis.tready = 1'b0;
      repeat (20) begin cyc(1500); cyc(0); end
      repeat (3) cyc(0);
      chk("t4_drop", drop_count, 5);
      chk("t4_evt", evt_count, 18);

      // 5: push into a full FIFO on the same edge as a pop
      cyc(1500); cyc(0);
      axis.tready = 1'b1;
      cyc(0);
      chk("t5_drop", drop_count, 5);
      chk("t5_evt", evt_count, 19);
      drain(100);
      chk("t45_beats", beats - b0, 17);

      // 6: enable drop and reset mid-pulse
      cyc(1500); cyc(1600);
      en = 1'b0;
      cyc(700);
      en = 1'b1;
      repeat (3) cyc(700);
      repeat (5) cyc(0);
      chk("t6_en_evt", evt_count, 19);
      cyc(1500); cyc(1600);
      rst_n = 1'b0;
      cyc(700);
      rst_n = 1'b1;
      chk("t6_rst_evt", evt_count, 0);
      chk("t6_rst_drop", drop_count, 0);
      chk("t6_rst_tvalid", axis.tvalid, 0);
      repeat (3) cyc(700);
      repeat (4) cyc(0);
      chk("t6_post_evt", evt_count, 0);

      // randomized traffic, stalls, enable glitches and rare resets
      burst = 0;
      for (int n = 0; n < 4000; n++) begin
         if ((n / 250) % 3 == 1) axis.tready = 1'b0;
         else axis.tready = ($urandom_range(0, 3) != 0);
         en    = ($urandom_range(0, 99) != 0);
         rst_n = ($urandom_range(0, 999) != 0);
         if (n % 500 == 0) begin
            hi = 14'($urandom_range(800, 1500));
            lo = 14'($urandom_range(300, 900));
         end
         if (burst > 0) begin
            v = int'($urandom_range(1500, 2500));
            burst--;
         end else if ($urandom_range(0, 99) < 2) begin
            burst = int'($urandom_range(6, 14));
            v = 2000;
         end else begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3, 4, 5: v = int'($urandom_range(0, 700)) - 200;
               6, 7, 8:          v = int'($urandom_range(600, 1400));
               default:          v = int'($urandom_range(1000, 3000));
            endcase
         end
         cyc(v);
      end
      en = 1'b1;
      rst_n = 1'b1;
      repeat (3) cyc(0);
      drain(200);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
